// File: rtl/cw305_seq_pkg.sv
// Shared types and layout constants for the CW305 job sequencer.
package cw305_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        START   = 3'd2,
        RUN     = 3'd3,
        STORE   = 3'd4
    } state_t;

    // Bit positions inside the status byte
    localparam int BUSY    = 0;
    localparam int DONE    = 1;
    localparam int TIMEOUT = 2;
    localparam int OVERRUN = 3;

    // Byte offsets inside memory_output
    localparam int STATUS_OFS = 0;
    localparam int COUNT_OFS  = 1;
    localparam int RESULT_OFS = 8;

    function automatic logic [7:0] status_byte(input logic busy, input logic done,
                                               input logic timeout, input logic overrun);
        logic [7:0] s;
        s          = 8'h00;
        s[BUSY]    = busy;
        s[DONE]    = done;
        s[TIMEOUT] = timeout;
        s[OVERRUN] = overrun;
        return s;
    endfunction

endpackage

// File: rtl/cw305_trigger_sync.sv
// Host trigger synchronizer and one-cycle rising-edge pulse generator.
module cw305_trigger_sync (
    input  logic clk_sys,
    input  logic rst,
    input  logic i_trigger,
    output logic o_rise
);

    logic r_s1, r_s2, r_s3, r_rise;
    logic r_v1, r_v2, r_armed;

    // Two-flop synchronizer, history flop and registered edge pulse. The v
    // flops mark when r_s2 holds a real sample; a trigger already high when
    // reset releases is a level, not a new edge, so the detector only arms
    // once a genuine low has been seen.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_rise  <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= i_trigger;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_rise  <= r_s2 & ~r_s3 & r_armed;
            r_v1    <= 1'b1;
            r_v2    <= r_v1;
            r_armed <= r_armed | (r_v2 & ~r_s2);
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/cw305_job_sequencer.sv
// Runs one core job per host trigger: snapshot input memory, start the core,
// wait for done or timeout, then publish status, cycle count and result.
module cw305_job_sequencer
    import cw305_seq_pkg::*;
#(
    parameter int          MEMORY_WIDTH   = 8,
    parameter int          MEMORY_BYTES   = 1 << MEMORY_WIDTH,
    parameter int          RESULT_BYTES   = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
    input  logic                      clk_sys,
    input  logic                      rst,
    input  logic                      trigger,
    input  logic [MEMORY_BYTES*8-1:0] memory_input,
    output logic [MEMORY_BYTES*8-1:0] memory_output,
    output logic [MEMORY_BYTES*8-1:0] core_input,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [RESULT_BYTES*8-1:0] core_result,
    output logic                      core_abort
);

    if (RESULT_BYTES > MEMORY_BYTES - 8) begin : g_bad_result_bytes
        $error("RESULT_BYTES must be <= MEMORY_BYTES-8");
    end
    if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_t                      r_state, w_next;
    logic                        w_rise;
    logic                        w_timeout_hit;
    logic [31:0]                 r_count;
    logic                        r_done, r_timeout, r_overrun, r_abort;
    logic [RESULT_BYTES*8-1:0]   r_result;
    logic [MEMORY_BYTES*8-1:0]   r_core_in;
    // Byte 0 is live status, so only bytes 1..end are stored
    logic [MEMORY_BYTES*8-1:8]   r_body, w_body;
    logic [7:0]                  w_status;

    cw305_trigger_sync u_trig (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .i_trigger (trigger),
        .o_rise    (w_rise)
    );

    assign w_timeout_hit = (r_count == TIMEOUT_CYCLES - 32'd1);

    // State register
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and the start strobe
    always_comb begin
        w_next     = r_state;
        core_start = 1'b0;
        case (r_state)
            IDLE:    if (w_rise) w_next = CAPTURE;
            CAPTURE: w_next = START;
            START: begin
                core_start = 1'b1;
                w_next     = RUN;
            end
            RUN:     if (core_done || w_timeout_hit) w_next = STORE;
            STORE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Job datapath: snapshot, cycle counter, result latch, flags, publish
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_core_in <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_body    <= '0;
        end else begin
            case (r_state)
                CAPTURE: begin
                    r_core_in <= memory_input;
                    r_count   <= '0;
                    r_done    <= 1'b0;
                    r_timeout <= 1'b0;
                end
                RUN: begin
                    r_count <= r_count + 32'd1;
                    // done takes priority over a coincident timeout
                    if (core_done) begin
                        r_result <= core_result;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_result  <= '0;
                    end
                end
                STORE: begin
                    r_body <= w_body;
                    r_done <= ~r_timeout;
                end
                default: ;
            endcase
        end
    end

    // Abort pulse is registered so it lands in the STORE cycle; overrun is
    // sticky until the next capture, but a new edge during CAPTURE still counts
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_abort   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_abort <= (r_state == RUN) && !core_done && w_timeout_hit;
            if (w_rise && r_state != IDLE) r_overrun <= 1'b1;
            else if (r_state == CAPTURE)   r_overrun <= 1'b0;
        end
    end

    // Output memory image: live status byte over the last published body
    always_comb begin
        w_body = '0;
        w_body[COUNT_OFS*8 +: 32]                 = r_count;
        w_body[RESULT_OFS*8 +: RESULT_BYTES*8]    = r_result;
        w_status = status_byte(r_state != IDLE, r_done, r_timeout, r_overrun);
        memory_output = {r_body, 8'h00};
        memory_output[STATUS_OFS*8 +: 8] = w_status;
    end

    assign core_input = r_core_in;
    assign core_abort = r_abort;

endmodule

// File: tb/tb_cw305_job_sequencer.sv
// Directed bench for cw305_job_sequencer with a 16-cycle timeout.
module tb_cw305_job_sequencer;

    localparam int MB = 256;
    localparam int RB = 32;

    logic              clk_sys;
    logic              rst;
    logic              trigger;
    logic [MB*8-1:0]   memory_input;
    logic [MB*8-1:0]   memory_output;
    logic [MB*8-1:0]   core_input;
    logic              core_start;
    logic              core_done;
    logic [RB*8-1:0]   core_result;
    logic              core_abort;

    int n_chk  = 0;
    int n_pass = 0;
    int start_cnt = 0;
    int abort_cnt = 0;

    cw305_job_sequencer #(
        .MEMORY_WIDTH   (8),
        .RESULT_BYTES   (RB),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .trigger       (trigger),
        .memory_input  (memory_input),
        .memory_output (memory_output),
        .core_input    (core_input),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_result   (core_result),
        .core_abort    (core_abort)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (core_start) start_cnt++;
        if (core_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Raise trigger just before edge E0; core_start must appear only after E4.
    // Returns at the negedge inside the START cycle.
    task automatic trig_and_wait();
        @(negedge clk_sys);
        trigger = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("latency_early", core_start, 1'b0);
        @(negedge clk_sys);
        chk("latency_start", core_start, 1'b1);
        trigger = 1'b0;
    endtask

    // Drives core_done in RUN cycle done_at; optionally fires a second
    // trigger edge and rewrites the input memory mid-run.
    task automatic run_job(input int done_at, input logic [7:0] r0, input bit ovr);
        for (int c = 1; c <= done_at; c++) begin
            @(negedge clk_sys);
            if (c == 1) chk("start_one_cycle", core_start, 1'b0);
            if (ovr && c == 2) begin
                trigger = 1'b1;
                memory_input[7:0] = 8'hFF;
            end
            if (ovr && c == 5) trigger = 1'b0;
            if (ovr && c == 8) chk("ovr_snapshot_stable", core_input[7:0], 8'hA5);
            if (c == done_at) begin
                core_result      = '0;
                core_result[7:0] = r0;
                core_done        = 1'b1;
            end
        end
        @(negedge clk_sys);
        core_done = 1'b0;
        @(negedge clk_sys);
    endtask

    int sc, ab;

    initial begin
        rst = 1'b1; trigger = 1'b1; memory_input = '0;
        core_done = 1'b0; core_result = '0;

        // Reset with trigger held high
        repeat (3) @(negedge clk_sys);
        chk("rst_out_zero", 64'(|memory_output), 0);
        chk("rst_core_in_zero", 64'(|core_input), 0);
        chk("rst_start", core_start, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk_sys);
        chk("held_trig_no_start", start_cnt, 0);
        chk("held_trig_out_zero", 64'(|memory_output), 0);
        chk("held_trig_byte0", memory_output[7:0], 8'h00);
        trigger = 1'b0;
        repeat (5) @(negedge clk_sys);

        // Normal job, done after 10 RUN cycles
        memory_input[7:0] = 8'hA5; memory_input[15:8] = 8'h11;
        trig_and_wait();
        chk("snap_byte0", core_input[7:0], 8'hA5);
        run_job(10, 8'h3C, 1'b0);
        chk("job_status", memory_output[7:0], 8'h02);
        chk("job_count", memory_output[8 +: 32], 10);
        chk("job_pad", memory_output[40 +: 24], 0);
        chk("job_result", memory_output[64 +: 8], 8'h3C);
        chk("job_core_in", core_input[15:0], 16'h11A5);
        chk("job_start_cnt", start_cnt, 1);

        // Timeout: core never finishes
        core_result[7:0] = 8'h77;
        trig_and_wait();
        ab = abort_cnt;
        repeat (16) @(negedge clk_sys);
        chk("abort_early", core_abort, 1'b0);
        @(negedge clk_sys);
        chk("abort_pulse", core_abort, 1'b1);
        @(negedge clk_sys);
        chk("abort_one_cycle", core_abort, 1'b0);
        chk("abort_count", abort_cnt - ab, 1);
        chk("to_status", memory_output[7:0], 8'h04);
        chk("to_count", memory_output[8 +: 32], 16);
        chk("to_result_zero", 64'(|memory_output[64 +: RB*8]), 0);

        // Overrun: second edge and host write during RUN
        memory_input[7:0] = 8'hA5;
        sc = start_cnt;
        trig_and_wait();
        run_job(10, 8'h6B, 1'b1);
        chk("ovr_status", memory_output[7:0], 8'h0A);
        chk("ovr_core_in", core_input[7:0], 8'hA5);
        repeat (8) @(negedge clk_sys);
        chk("ovr_single_start", start_cnt - sc, 1);

        // core_done on the exact timeout cycle
        memory_input[7:0] = 8'h42;
        trig_and_wait();
        ab = abort_cnt;
        run_job(16, 8'h5A, 1'b0);
        repeat (2) @(negedge clk_sys);
        chk("tie_no_abort", abort_cnt - ab, 0);
        chk("tie_status", memory_output[7:0], 8'h02);
        chk("tie_count", memory_output[8 +: 32], 16);
        chk("tie_result", memory_output[64 +: 8], 8'h5A);

        // Reset in the middle of a job that has already overrun
        trig_and_wait();
        repeat (2) @(negedge clk_sys);
        trigger = 1'b1;
        repeat (4) @(negedge clk_sys);
        trigger = 1'b0;
        chk("mid_status", memory_output[7:0], 8'h09);
        #2 rst = 1'b1;
        #1;
        chk("async_out_zero", 64'(|memory_output), 0);
        chk("async_core_in_zero", 64'(|core_input), 0);
        chk("async_start", core_start, 1'b0);
        chk("async_abort", core_abort, 1'b0);
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        sc = start_cnt;
        repeat (6) @(negedge clk_sys);
        chk("rel_no_start", start_cnt - sc, 0);
        chk("rel_status", memory_output[7:0], 8'h00);

        // Fresh job after reset
        memory_input[7:0] = 8'h5A;
        trig_and_wait();
        chk("fresh_snap", core_input[7:0], 8'h5A);
        run_job(5, 8'hC3, 1'b0);
        chk("fresh_status", memory_output[7:0], 8'h02);
        chk("fresh_count", memory_output[8 +: 32], 5);
        chk("fresh_result", memory_output[64 +: 8], 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cw305_job_sequencer.md
Name: cw305_job_sequencer

Overview:
- Sequences one crypto/core "job" per host trigger on the CW305 target.
- Snapshots the host-writable input memory into a stable shadow copy and starts the core.
- Waits for the core to finish or time out, then publishes status, cycle count and result into the host-readable output memory.
- Sits between the USB register module (its memory_input/memory_output buses) and the compute core; runs entirely in clk_sys.

Parameters:
- MEMORY_WIDTH, 8, log2 of memory size in bytes.
- MEMORY_BYTES, 1<<MEMORY_WIDTH (256), byte count of each memory bus.
- RESULT_BYTES, 32, core result width in bytes; must be ≤ MEMORY_BYTES-8 (elaboration error otherwise).
- TIMEOUT_CYCLES, 32'h00FF_FFFF, maximum RUN cycles before abort; must be ≥ 2.

Ports:
- clk_sys  in  1  system clock (buffered USB clock).
- rst  in  1  asynchronous, active-high reset.
- trigger  in  1  host trigger pin; asynchronous level.
- memory_input  in  MEMORY_BYTES*8  host-written input memory.
- memory_output  out  MEMORY_BYTES*8  host-readable output memory.
- core_input  out  MEMORY_BYTES*8  shadow snapshot presented to the core.
- core_start  out  1  one-cycle start pulse.
- core_done  in  1  core completion; level or pulse, sampled only in RUN.
- core_result  in  RESULT_BYTES*8  core result; valid while core_done=1.
- core_abort  out  1  one-cycle abort pulse on timeout.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; memory_output, core_input, cycle counter, status flags and sync flops all 0.
  - core_start=0, core_abort=0.
  - Reset mid-job drops the job immediately; no pulse is emitted on release.
- Trigger input:
  - 2-flop synchronizer, then rising-edge detect (trig_rise = s2 & ~s3).
  - Edge E0 samples trigger high; trig_rise is high in the cycle after E2.
- FSM states: IDLE, CAPTURE, START, RUN, STORE.
- IDLE:
  - On trig_rise → CAPTURE.
  - Otherwise hold.
- CAPTURE (1 cycle):
  - core_input <= memory_input.
  - done/timeout flags cleared; cycle counter <= 0.
  - → START.
- START (1 cycle):
  - core_start=1 for exactly this cycle.
  - → RUN.
- RUN:
  - Counter increments by 1 every RUN cycle, including the cycle core_done is seen.
  - If core_done=1: latch core_result, → STORE.
  - Else if counter == TIMEOUT_CYCLES-1: core_abort=1 for one cycle, set timeout flag, zero the result latch, → STORE.
  - If core_done and timeout coincide in the same cycle, done wins: result is kept, no abort, timeout flag stays 0.
- STORE (1 cycle):
  - Write memory_output.
  - Set done flag if completed normally.
  - → IDLE.
- Overrun: trig_rise in any state other than IDLE sets a sticky overrun flag and is otherwise ignored (no queueing). Overrun is cleared only by the next CAPTURE.
- memory_output layout:
  - Byte 0 = status {4'b0, overrun, timeout, done, busy}, with busy = (state != IDLE).
  - Bytes 1..4 = cycle count, little-endian, from the final counter value.
  - Bytes 5..7 = 0.
  - Bytes 8..8+RESULT_BYTES-1 = result.
  - Remaining bytes = 0.
  - Byte 0 updates every cycle.
  - Bytes 1..end change only in STORE and retain their values across later CAPTUREs until the next STORE.
- Counter is 32 bits and cannot overflow because the timeout bounds it.
- Latency: trigger sampled high at E0 → core_start high in the cycle following E4.
- core_input is stable from CAPTURE until the next CAPTURE; host writes during RUN do not disturb the core.

Decomposition:
- Package cw305_seq_pkg holds:
  - state enum (IDLE, CAPTURE, START, RUN, STORE);
  - status bit indices (BUSY=0, DONE=1, TIMEOUT=2, OVERRUN=3);
  - byte offsets (STATUS_OFS=0, COUNT_OFS=1, RESULT_OFS=8).
- One sub-module, cw305_trigger_sync: 2-flop synchronizer plus edge detect, with async reset.

Test Plan:
- Reset with trigger=1 held, then release rst → no core_start ever; memory_output==0; byte0==8'h00.
- memory_input byte0=8'hA5, pulse trigger; core asserts core_done 10 cycles after core_start with result byte0=8'h3C:
  - core_start asserted exactly 1 cycle;
  - out byte0=8'h02, bytes1..4=10, byte8=8'h3C;
  - core_input byte0=8'hA5.
- TIMEOUT_CYCLES=16, core never done:
  - core_abort is a 1-cycle pulse after the 16th RUN cycle;
  - byte0=8'h04, count=16, result bytes=0.
- Second trigger edge during RUN, then host writes memory_input byte0=8'hFF mid-run:
  - core_input byte0 stays 8'hA5;
  - final byte0=8'h0A (overrun+done);
  - only one core_start.
- core_done asserted on the exact timeout cycle → no core_abort, byte0=8'h02, result captured.
- Assert rst during RUN:
  - all outputs 0 within the same cycle, with no clock needed;
  - after release, a fresh trigger runs a normal job with overrun=0.
